gen_param_loader: RTL and testbench
===================================

Name: gen_param_loader

Overview:
- Sequential parameter loader sitting directly upstream of the 2-3-9 generator MLP.
- Accepts weights/biases as a serial word stream over a valid/ready handshake and assembles them into the flat packed buses the generator consumes.
- Asserts params_valid once a complete, consistent set is held.
- Holds parameters stable between loads so the combinational generator sees static operands.

Parameters:
- WIDTH, 32, signed word width of every weight/bias
- N_INPUT, 2, generator inputs (layer-2 fan-in)
- N_NEURON_L2, 3, hidden neurons (layer-3 fan-in)
- N_NEURON_L3, 9, output neurons (3x3 pixels)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- load_start  in  1  one-cycle pulse; begins (or restarts) a load
- in_data  in  WIDTH  signed parameter word
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts a word this cycle
- w_L2  out  N_INPUT*N_NEURON_L2*WIDTH  layer-2 weights, packed
- b_L2  out  N_NEURON_L2*WIDTH  layer-2 biases, packed
- w_L3  out  N_NEURON_L2*N_NEURON_L3*WIDTH  layer-3 weights, packed
- b_L3  out  N_NEURON_L3*WIDTH  layer-3 biases, packed
- params_valid  out  1  complete parameter set held
- word_idx  out  6  index of next word expected (0..TOTAL-1)
- checksum_err  out  1  sticky checksum mismatch (see Optional Feature)

Behaviour:
- Word counts:
  - NW2 = N_INPUT*N_NEURON_L2 = 6
  - NB2 = 3
  - NW3 = N_NEURON_L2*N_NEURON_L3 = 27
  - NB3 = 9
  - TOTAL = 45
- Stream order: w_L2 words 0..NW2-1, then b_L2, then w_L3, then b_L3.
- Bus placement: word k of a bus occupies bits [(k+1)*WIDTH-1 : k*WIDTH].
  - w_L2 word k = N_INPUT*i + m, for neuron i, input m.
  - w_L3 word k = N_NEURON_L2*j + m, for neuron j, hidden m.
- Reset (async, rst_n=0): state IDLE; all param buses 0; params_valid 0; word_idx 0; checksum_err 0; in_ready 0.
- FSM states: IDLE, LOAD, DONE (plus CHECK with the optional feature).
  - IDLE/DONE + load_start -> LOAD next cycle. Also on that edge: params_valid<=0, word_idx<=0, checksum_err<=0. Param registers are NOT cleared.
  - LOAD: in_ready=1 (decoded from state, no combinational dependence on in_valid).
    - A word is accepted when in_valid & in_ready. It is written to its slot on that edge and word_idx increments.
    - When word TOTAL-1 is accepted -> DONE. params_valid=1 from the following cycle (latency 1 clock after last handshake).
  - LOAD + load_start: restart. word_idx<=0, and any word presented that same cycle is discarded (not written). Earlier-written slots retain stale values until overwritten.
  - DONE: in_ready=0; buses and params_valid hold indefinitely.
- in_valid while in_ready=0 is ignored; no backpressure is violated.
- Reset asserted mid-load: immediate return to reset values; params_valid never asserts for the partial set.
- word_idx never exceeds TOTAL-1; no wrap inside LOAD.
- No arithmetic on data except the optional checksum (sum modulo 2^WIDTH, two's complement wrap).

Optional Feature:
- Macro: GEN_PARAM_CHECKSUM_EN.
- Defined:
  - Loader keeps a running sum of accepted words, reset to 0 on load_start.
  - After word TOTAL-1, goes to CHECK (in_ready=1, word_idx=TOTAL) and accepts exactly one checksum word.
  - Match -> DONE, params_valid=1 next cycle.
  - Mismatch -> IDLE, checksum_err=1 (sticky until next load_start/reset), params_valid stays 0.
  - load_start in CHECK restarts as in LOAD.
- Undefined: no CHECK state; checksum_err tied 0; TOTAL words end the load.

Test Plan:
- Reset, then load_start, then 45 words with values 1..45, in_valid held high -> done 45 cycles after the first accept:
  - w_L2 word0=1, b_L2 word0=7, w_L3 word26=36, b_L3 word8=45.
  - params_valid rises 1 cycle after the 45th handshake; in_ready falls the same cycle.
- Same stream with in_valid toggling every other cycle -> identical bus contents; word_idx advances only on handshakes.
- load_start pulsed after 20 words, coincident with a valid word 0x7FFFFFFF, then 45 words of 0xFFFFFFFF -> 0x7FFFFFFF is never written; all slots = 0xFFFFFFFF; params_valid=1.
- rst_n dropped asynchronously at word 30 -> all outputs 0 immediately; a subsequent full load behaves as the first scenario.
- Words presented in DONE with in_valid=1 -> no change to buses; in_ready=0; params_valid stays 1.
- GEN_PARAM_CHECKSUM_EN, words 1..45:
  - checksum 1035 -> params_valid=1.
  - checksum 1034 -> checksum_err=1, params_valid=0, state IDLE.

Source files
------------

// File: rtl/gen_param_loader.sv
// -----------------------------------------------------------------------------
// gen_param_loader
//
// Serial parameter loader for the 2-3-9 generator MLP. It takes one signed
// weight/bias word per valid/ready handshake and places it into the flat
// packed buses the combinational generator reads. The buses hold their
// values between loads. params_valid is high only while a complete set from
// the most recent load is held.
//
// Stream order: w_L2[0..NW2-1], b_L2[0..NB2-1], w_L3[0..NW3-1], b_L3[0..NB3-1].
// Word k of any bus occupies bits [(k+1)*WIDTH-1 : k*WIDTH].
//
// Optional feature (macro GEN_PARAM_CHECKSUM_EN):
//   After the last parameter word, one extra checksum word is accepted in the
//   CHECK state. That word must equal the modulo-2^WIDTH sum of all accepted
//   words. A match completes the load. A mismatch returns the FSM to IDLE and
//   sets the sticky checksum_err flag. When the macro is undefined,
//   checksum_err is tied to 0.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   load_start    one-cycle pulse; starts or restarts a load
//   in_data       parameter word (signed, WIDTH bits)
//   in_valid      in_data is valid
//   in_ready      loader accepts a word this cycle (decoded from state only)
//   w_L2, b_L2    layer-2 weights / biases, packed
//   w_L3, b_L3    layer-3 weights / biases, packed
//   params_valid  complete parameter set held
//   word_idx      index of the next word expected
//   checksum_err  sticky checksum mismatch flag
// -----------------------------------------------------------------------------
module gen_param_loader #(
   parameter int WIDTH       = 32,
   parameter int N_INPUT     = 2,
   parameter int N_NEURON_L2 = 3,
   parameter int N_NEURON_L3 = 9
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   load_start,
   input  logic [WIDTH-1:0]                       in_data,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   output logic [N_INPUT*N_NEURON_L2*WIDTH-1:0]     w_L2,
   output logic [N_NEURON_L2*WIDTH-1:0]             b_L2,
   output logic [N_NEURON_L2*N_NEURON_L3*WIDTH-1:0] w_L3,
   output logic [N_NEURON_L3*WIDTH-1:0]             b_L3,
   output logic                                   params_valid,
   output logic [5:0]                             word_idx,
   output logic                                   checksum_err
);

   localparam int NW2   = N_INPUT * N_NEURON_L2;
   localparam int NB2   = N_NEURON_L2;
   localparam int NW3   = N_NEURON_L2 * N_NEURON_L3;
   localparam int NB3   = N_NEURON_L3;
   localparam int TOTAL = NW2 + NB2 + NW3 + NB3;

   localparam logic [5:0] LAST_IDX = 6'(TOTAL - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DONE  = 2'd2
`ifdef GEN_PARAM_CHECKSUM_EN
      ,
      CHECK = 2'd3
`endif
   } state_t;

   state_t            state_reg;
   state_t            state_next;
   logic [5:0]        word_idx_reg;
   logic              load_take;    // parameter word written this cycle
   logic [TOTAL*WIDTH-1:0] param_flat;

`ifdef GEN_PARAM_CHECKSUM_EN
   logic              check_take;   // checksum word consumed this cycle
   logic [WIDTH-1:0]  sum_reg;
   logic              err_reg;
`endif

   // ------------------------------------------------------------------
   // Next-state and output decode. A load_start always wins over a
   // coincident word, so that word is dropped rather than written into
   // the slot of the load being abandoned.
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      load_take  = 1'b0;
`ifdef GEN_PARAM_CHECKSUM_EN
      check_take = 1'b0;
`endif
      case (state_reg)
         IDLE, DONE: begin
            if (load_start) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            in_ready = 1'b1;
            if (load_start) begin
               state_next = LOAD;
            end else if (in_valid) begin
               load_take = 1'b1;
               if (word_idx_reg == LAST_IDX) begin
`ifdef GEN_PARAM_CHECKSUM_EN
                  state_next = CHECK;
`else
                  state_next = DONE;
`endif
               end
            end
         end
`ifdef GEN_PARAM_CHECKSUM_EN
         CHECK: begin
            in_ready = 1'b1;
            if (load_start) begin
               state_next = LOAD;
            end else if (in_valid) begin
               check_take = 1'b1;
               state_next = (in_data == sum_reg) ? DONE : IDLE;
            end
         end
`endif
         default: state_next = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // State register and word index
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         word_idx_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (load_start) begin
            word_idx_reg <= '0;
         end else if (load_take && (word_idx_reg != LAST_IDX)) begin
            word_idx_reg <= word_idx_reg + 6'd1;
         end
`ifdef GEN_PARAM_CHECKSUM_EN
         // The index parks at TOTAL while the loader waits for the checksum.
         else if (load_take) begin
            word_idx_reg <= 6'(TOTAL);
         end
`endif
      end
   end

   // ------------------------------------------------------------------
   // One register per stream slot. Each slot register is local to its
   // generate block, so every bit of param_flat has a single driver.
   // load_start does not clear these registers. Stale words from an
   // abandoned load stay in place until the new load overwrites them.
   // ------------------------------------------------------------------
   for (genvar gi = 0; gi < TOTAL; gi++) begin : g_slot
      logic [WIDTH-1:0] slot_reg;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            slot_reg <= '0;
         end else if (load_take && (word_idx_reg == 6'(gi))) begin
            slot_reg <= in_data;
         end
      end

      assign param_flat[gi*WIDTH +: WIDTH] = slot_reg;
   end

   // The stream order matches the bus concatenation, so each bus is a
   // plain slice of the slot vector.
   assign w_L2 = param_flat[NW2*WIDTH-1 : 0];
   assign b_L2 = param_flat[(NW2+NB2)*WIDTH-1 : NW2*WIDTH];
   assign w_L3 = param_flat[(NW2+NB2+NW3)*WIDTH-1 : (NW2+NB2)*WIDTH];
   assign b_L3 = param_flat[TOTAL*WIDTH-1 : (NW2+NB2+NW3)*WIDTH];

   assign params_valid = (state_reg == DONE);
   assign word_idx     = word_idx_reg;

   // ------------------------------------------------------------------
   // Running checksum (two's-complement wrap) and sticky error flag
   // ------------------------------------------------------------------
`ifdef GEN_PARAM_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_reg <= '0;
         err_reg <= 1'b0;
      end else if (load_start) begin
         sum_reg <= '0;
         err_reg <= 1'b0;
      end else if (load_take) begin
         sum_reg <= sum_reg + in_data;
      end else if (check_take && (in_data != sum_reg)) begin
         err_reg <= 1'b1;
      end
   end

   assign checksum_err = err_reg;
`else
   assign checksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_gen_param_loader.sv
// -----------------------------------------------------------------------------
// tb_gen_param_loader
//
// Self-checking bench for gen_param_loader. A stream-level reference model
// tracks the expected load state, the next index, the running sum and the
// contents of every stream slot. The bench compares in_ready, params_valid,
// word_idx and checksum_err against the model every cycle. After each load it
// compares every bus word with the model. A spot table of known placements
// checks the counting stream 1..45.
// -----------------------------------------------------------------------------
module tb_gen_param_loader;

   localparam int W     = 32;
   localparam int NW2   = 6;
   localparam int NB2   = 3;
   localparam int NW3   = 27;
   localparam int NB3   = 9;
   localparam int TOTAL = NW2 + NB2 + NW3 + NB3;

   localparam int M_IDLE  = 0;
   localparam int M_LOAD  = 1;
   localparam int M_DONE  = 2;
   localparam int M_CHECK = 3;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               load_start;
   logic [W-1:0]       in_data;
   logic               in_valid;
   logic               in_ready;
   logic [NW2*W-1:0]   w_L2;
   logic [NB2*W-1:0]   b_L2;
   logic [NW3*W-1:0]   w_L3;
   logic [NB3*W-1:0]   b_L3;
   logic               params_valid;
   logic [5:0]         word_idx;
   logic               checksum_err;

   gen_param_loader #(
      .WIDTH       (W),
      .N_INPUT     (2),
      .N_NEURON_L2 (3),
      .N_NEURON_L3 (9)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_start   (load_start),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .w_L2         (w_L2),
      .b_L2         (b_L2),
      .w_L3         (w_L3),
      .b_L3         (b_L3),
      .params_valid (params_valid),
      .word_idx     (word_idx),
      .checksum_err (checksum_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model
   int           mstate;
   int           midx;
   logic [W-1:0] msum;
   bit           merr;
   logic [W-1:0] mmem [TOTAL];

   typedef struct {
      int           bus;   // 0:w_L2 1:b_L2 2:w_L3 3:b_L3
      int           idx;   // word index within the bus
      logic [W-1:0] exp;
   } spot_t;

   spot_t spots [9];

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic budget_fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: cycle budget expired, got no completion expected completion", name);
   endtask

   function automatic logic [W-1:0] bus_word(input int bus, input int idx);
      case (bus)
         0:       return w_L2[idx*W +: W];
         1:       return b_L2[idx*W +: W];
         2:       return w_L3[idx*W +: W];
         default: return b_L3[idx*W +: W];
      endcase
   endfunction

   // Map a stream position to the bus word the DUT should have placed it in
   function automatic logic [W-1:0] stream_word(input int k);
      if (k < NW2)                  return bus_word(0, k);
      else if (k < NW2 + NB2)       return bus_word(1, k - NW2);
      else if (k < NW2 + NB2 + NW3) return bus_word(2, k - NW2 - NB2);
      else                          return bus_word(3, k - NW2 - NB2 - NW3);
   endfunction

   task automatic model_reset();
      mstate = M_IDLE;
      midx   = 0;
      msum   = '0;
      merr   = 1'b0;
      for (int k = 0; k < TOTAL; k++) mmem[k] = '0;
   endtask

   task automatic check_outputs();
      chk("in_ready", 32'(in_ready), 32'((mstate == M_LOAD) || (mstate == M_CHECK)));
      chk("params_valid", 32'(params_valid), 32'(mstate == M_DONE));
      chk("checksum_err", 32'(checksum_err), 32'(merr));
      if ((mstate == M_LOAD) || (mstate == M_CHECK))
         chk("word_idx", 32'(word_idx), 32'(midx));
   endtask

   task automatic check_buses(input string tag);
      for (int k = 0; k < TOTAL; k++) chk(tag, stream_word(k), mmem[k]);
   endtask

   task automatic check_spots();
      for (int i = 0; i < 9; i++)
         chk("spot", bus_word(spots[i].bus, spots[i].idx), spots[i].exp);
   endtask

   // Called at a falling edge: drive the inputs, check the outputs, advance
   // one clock, then update the model.
   task automatic cycle(input bit ls, input bit v, input logic [W-1:0] d);
      load_start = ls;
      in_valid   = v;
      in_data    = d;
      #1;
      check_outputs();
      @(posedge clk);
      if (ls) begin
         mstate = M_LOAD;
         midx   = 0;
         msum   = '0;
         merr   = 1'b0;
      end else if (v && (mstate == M_LOAD)) begin
         mmem[midx] = d;
         msum       = msum + d;
         if (midx == TOTAL - 1) begin
`ifdef GEN_PARAM_CHECKSUM_EN
            mstate = M_CHECK;
            midx   = TOTAL;
`else
            mstate = M_DONE;
`endif
         end else begin
            midx++;
         end
      end else if (v && (mstate == M_CHECK)) begin
         if (d == msum) begin
            mstate = M_DONE;
         end else begin
            mstate = M_IDLE;
            merr   = 1'b1;
         end
      end
      @(negedge clk);
      load_start = 1'b0;
      in_valid   = 1'b0;
   endtask

   // Feed words until the model leaves LOAD/CHECK.
   // mode 0: value = index+1 with valid held high
   // mode 1: all-ones words
   // mode 2: value = index+1 with valid toggling every cycle
   // In CHECK, the correct checksum is sent.
   task automatic run_to_end(input int mode, output int ncyc);
      bit           v;
      logic [W-1:0] d;
      ncyc = 0;
      while (((mstate == M_LOAD) || (mstate == M_CHECK)) && (ncyc < 400)) begin
         v = (mode == 2) ? ncyc[0] : 1'b1;
         d = (mode == 1) ? 32'hFFFF_FFFF : 32'(midx + 1);
         if (mstate == M_CHECK) d = msum;
         cycle(1'b0, v, d);
         ncyc++;
      end
      if (ncyc >= 400) budget_fail("run_to_end");
   endtask

   task automatic feed_random_until(input int stop_idx);
      int n = 0;
      while ((mstate == M_LOAD) && (midx < stop_idx) && (n < 200)) begin
         cycle(1'b0, 1'b1, $urandom);
         n++;
      end
      if (n >= 200) budget_fail("feed_random_until");
   endtask

   initial begin
      int ncyc;
      int n;
      bit restarted;

      spots[0] = '{0, 0,  32'd1};
      spots[1] = '{0, 5,  32'd6};
      spots[2] = '{1, 0,  32'd7};
      spots[3] = '{1, 2,  32'd9};
      spots[4] = '{2, 0,  32'd10};
      spots[5] = '{2, 7,  32'd17};   // w_L3 neuron 2, hidden 1
      spots[6] = '{2, 26, 32'd36};
      spots[7] = '{3, 0,  32'd37};
      spots[8] = '{3, 8,  32'd45};

      // Reset state
      rst_n      = 1'b0;
      load_start = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      model_reset();
      #1;
      check_outputs();
      chk("rst_word_idx", 32'(word_idx), 32'd0);
      check_buses("rst_bus");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Counting stream, valid held high
      cycle(1'b1, 1'b0, '0);
      run_to_end(0, ncyc);
      check_outputs();
`ifndef GEN_PARAM_CHECKSUM_EN
      chk("cycles_to_done", 32'(ncyc), 32'd45);
`endif
      check_spots();
      check_buses("count_bus");
      $display("count stream: load finished after %0d cycles", ncyc);

      // Words offered in DONE are ignored
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, $urandom);
      check_outputs();
      check_buses("done_hold");
      $display("done hold: 6 words offered in DONE, buses unchanged");

      // Same stream with valid toggling every cycle
      cycle(1'b1, 1'b0, '0);
      run_to_end(2, ncyc);
      check_outputs();
      check_spots();
      check_buses("toggle_bus");
      $display("toggle stream: load finished after %0d cycles", ncyc);

      // Restart after 20 words, coincident with a valid word that must be dropped
      cycle(1'b1, 1'b0, '0);
      feed_random_until(20);
      cycle(1'b1, 1'b1, 32'h7FFF_FFFF);
      run_to_end(1, ncyc);
      check_outputs();
      for (int k = 0; k < TOTAL; k++) chk("restart_slot", stream_word(k), 32'hFFFF_FFFF);
      $display("restart: all slots checked for 0xFFFFFFFF");

      // Asynchronous reset during word 30
      cycle(1'b1, 1'b0, '0);
      feed_random_until(30);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      chk("async_rst_word_idx", 32'(word_idx), 32'd0);
      check_buses("async_rst_bus");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      cycle(1'b1, 1'b0, '0);
      run_to_end(0, ncyc);
      check_outputs();
      check_spots();
      check_buses("post_rst_bus");
      $display("async reset: reload finished after %0d cycles", ncyc);

`ifdef GEN_PARAM_CHECKSUM_EN
      // Checksum of the words 1..45 is 1035
      cycle(1'b1, 1'b0, '0);
      for (int k = 0; k < TOTAL; k++) cycle(1'b0, 1'b1, 32'(k + 1));
      chk("ck_idx", 32'(word_idx), 32'd45);
      cycle(1'b0, 1'b1, 32'd1035);
      check_outputs();
      chk("ck_good_valid", 32'(params_valid), 32'd1);
      $display("checksum 1035: params_valid=%0d", params_valid);

      cycle(1'b1, 1'b0, '0);
      for (int k = 0; k < TOTAL; k++) cycle(1'b0, 1'b1, 32'(k + 1));
      cycle(1'b0, 1'b1, 32'd1034);
      check_outputs();
      chk("ck_bad_err", 32'(checksum_err), 32'd1);
      chk("ck_bad_valid", 32'(params_valid), 32'd0);
      chk("ck_bad_ready", 32'(in_ready), 32'd0);
      $display("checksum 1034: checksum_err=%0d", checksum_err);
`endif

      // Random data with random valid gaps and at most one random restart
      for (int r = 0; r < 4; r++) begin
         cycle(1'b1, 1'b0, '0);
         n = 0;
         restarted = 1'b0;
         while ((mstate != M_DONE) && (n < 600)) begin
            bit ls;
            ls = !restarted && (mstate == M_LOAD) && ($urandom_range(0, 59) == 0);
            if (ls) restarted = 1'b1;
            cycle(ls, ($urandom_range(0, 3) != 0),
                  (mstate == M_CHECK) ? msum : $urandom);
            n++;
         end
         if (n >= 600) budget_fail("random_load");
         check_outputs();
         check_buses("rand_bus");
         $display("random load %0d: %0d cycles, restart=%0d", r, n, restarted);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
